// File: rtl/branch_ex_stage.sv
// branch_ex_stage -- execute stage of a five-stage pipeline with branch/jump
// resolution and an EX/MEM output register with valid/ready handshaking.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready : ID/EX entry handshake; accepted when both are high
//   pc2, ALUSrc2, MemtoReg2, RegWrite2, MemWrite2, nPC_sel2, jmp2, ALUctr2,
//   busA2, busB2, Ext_out2, RW2 : ID/EX instruction fields
//   mem_ready         : MEM stage accepts the EX/MEM entry
//   em_*              : EX/MEM register outputs (valid, ALU result, store data,
//                       destination register, control bits)
//   redirect, redirect_pc, flush : registered one-cycle PC redirect and
//                       IF/ID clear after a taken branch or jump
module branch_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc2,
  input  logic        ALUSrc2,
  input  logic        MemtoReg2,
  input  logic        RegWrite2,
  input  logic        MemWrite2,
  input  logic        nPC_sel2,
  input  logic        jmp2,
  input  logic [1:0]  ALUctr2,
  input  logic [31:0] busA2,
  input  logic [31:0] busB2,
  input  logic [31:0] Ext_out2,
  input  logic [4:0]  RW2,
  input  logic        mem_ready,
  output logic        em_valid,
  output logic [31:0] em_alu_out,
  output logic [31:0] em_wdata,
  output logic [4:0]  em_RW,
  output logic        em_MemtoReg,
  output logic        em_RegWrite,
  output logic        em_MemWrite,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush
);

  typedef enum logic {RUN, SQUASH} state_t;

  state_t state, state_nxt;

  function automatic logic [31:0] alu_op(input logic [1:0] op,
                                         input logic signed [31:0] a,
                                         input logic signed [31:0] b);
    logic [31:0] res;
    case (op)
      2'b00:   res = a + b;
      2'b01:   res = a - b;
      2'b10:   res = a | b;
      default: res = {31'd0, (a < b)};
    endcase
    return res;
  endfunction

  // Stage p0: combinational execute on the ID/EX entry
  logic signed [31:0] alu_a_p0;
  logic signed [31:0] alu_b_p0;
  logic [31:0]        alu_res_p0;
  logic [31:0]        pc_plus4_p0;
  logic [31:0]        br_tgt_p0;
  logic [31:0]        jmp_tgt_p0;
  logic [31:0]        tgt_p0;
  logic               taken_p0;
  logic               accept_p0;

  assign alu_a_p0    = busA2;
  assign alu_b_p0    = ALUSrc2 ? Ext_out2 : busB2;
  assign alu_res_p0  = alu_op(ALUctr2, alu_a_p0, alu_b_p0);
  assign pc_plus4_p0 = pc2 + 32'd4;
  assign br_tgt_p0   = pc_plus4_p0 + {Ext_out2[29:0], 2'b00};
  assign jmp_tgt_p0  = {pc_plus4_p0[31:28], Ext_out2[25:0], 2'b00};
  // Branch compare always uses busB2, independent of ALUSrc2; jump wins.
  assign taken_p0    = jmp2 | (nPC_sel2 & (busA2 == busB2));
  assign tgt_p0      = jmp2 ? jmp_tgt_p0 : br_tgt_p0;

  // In SQUASH the presented entry is drained (ready) but never loaded.
  assign in_ready  = (state == SQUASH) | !em_valid | mem_ready;
  assign accept_p0 = in_valid & in_ready & (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (accept_p0 && taken_p0) state_nxt = SQUASH;
      SQUASH:  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  // Stage p1: EX/MEM register and redirect outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      em_valid    <= 1'b0;
      em_alu_out  <= 32'd0;
      em_wdata    <= 32'd0;
      em_RW       <= 5'd0;
      em_MemtoReg <= 1'b0;
      em_RegWrite <= 1'b0;
      em_MemWrite <= 1'b0;
      redirect    <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= 32'd0;
    end else begin
      if (accept_p0) begin
        em_valid    <= 1'b1;
        em_alu_out  <= alu_res_p0;
        em_wdata    <= busB2;
        em_RW       <= RW2;
        em_MemtoReg <= MemtoReg2;
        em_RegWrite <= RegWrite2;
        em_MemWrite <= MemWrite2;
      end else if (em_valid && mem_ready) begin
        em_valid <= 1'b0;
      end
      redirect <= accept_p0 & taken_p0;
      flush    <= accept_p0 & taken_p0;
      if (accept_p0 && taken_p0) redirect_pc <= tgt_p0;
    end
  end

endmodule

// File: tb/tb_branch_ex_stage.sv
// Directed testbench for branch_ex_stage: reset, ALU operations, branch and
// jump redirect with squash, back-pressure stall, and reset during squash.
module tb_branch_ex_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc2;
  logic        ALUSrc2, MemtoReg2, RegWrite2, MemWrite2, nPC_sel2, jmp2;
  logic [1:0]  ALUctr2;
  logic [31:0] busA2, busB2, Ext_out2;
  logic [4:0]  RW2;
  logic        mem_ready;
  logic        em_valid;
  logic [31:0] em_alu_out, em_wdata;
  logic [4:0]  em_RW;
  logic        em_MemtoReg, em_RegWrite, em_MemWrite;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;

  int checks = 0;
  int errors = 0;

  branch_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc2(pc2), .ALUSrc2(ALUSrc2), .MemtoReg2(MemtoReg2), .RegWrite2(RegWrite2),
    .MemWrite2(MemWrite2), .nPC_sel2(nPC_sel2), .jmp2(jmp2), .ALUctr2(ALUctr2),
    .busA2(busA2), .busB2(busB2), .Ext_out2(Ext_out2), .RW2(RW2),
    .mem_ready(mem_ready), .em_valid(em_valid), .em_alu_out(em_alu_out),
    .em_wdata(em_wdata), .em_RW(em_RW), .em_MemtoReg(em_MemtoReg),
    .em_RegWrite(em_RegWrite), .em_MemWrite(em_MemWrite),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; pc2 = 0; ALUSrc2 = 0; MemtoReg2 = 0; RegWrite2 = 0;
    MemWrite2 = 0; nPC_sel2 = 0; jmp2 = 0; ALUctr2 = 0; busA2 = 0;
    busB2 = 0; Ext_out2 = 0; RW2 = 0; mem_ready = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    clear_inputs();
    step();
    step();
    checks++; if (em_valid !== 1'b0) begin errors++; $display("FAIL reset_em_valid: got %b expected 0", em_valid); end
    checks++; if (redirect !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b/%b expected 0/0", redirect, flush); end
    checks++; if (redirect_pc !== 32'd0) begin errors++; $display("FAIL reset_redirect_pc: got %h expected 0", redirect_pc); end
    checks++; if ({em_alu_out, em_wdata, em_RW} !== 69'd0) begin errors++; $display("FAIL reset_em_data: got %h %h %h expected 0", em_alu_out, em_wdata, em_RW); end
    checks++; if ({em_MemtoReg, em_RegWrite, em_MemWrite} !== 3'b000) begin errors++; $display("FAIL reset_em_ctrl: got %b%b%b expected 000", em_MemtoReg, em_RegWrite, em_MemWrite); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst = 1;
  endtask

  task automatic test_alu();
    // 5 - 7 wraps to 0xFFFFFFFE
    clear_inputs();
    in_valid = 1; ALUctr2 = 2'b01; busA2 = 5; busB2 = 7; RW2 = 5'd3; RegWrite2 = 1;
    step();
    checks++; if (em_valid !== 1'b1) begin errors++; $display("FAIL sub_valid: got %b expected 1", em_valid); end
    checks++; if (em_alu_out !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_result: got %h expected fffffffe", em_alu_out); end
    checks++; if (em_wdata !== 32'd7 || em_RW !== 5'd3 || em_RegWrite !== 1'b1) begin errors++; $display("FAIL sub_fields: got %h %0d %b expected 7 3 1", em_wdata, em_RW, em_RegWrite); end
    // signed -1 < 1 with immediate; store data remains busB2
    clear_inputs();
    in_valid = 1; ALUctr2 = 2'b11; busA2 = 32'hFFFF_FFFF; busB2 = 32'h55; ALUSrc2 = 1; Ext_out2 = 1; MemWrite2 = 1;
    step();
    checks++; if (em_alu_out !== 32'd1) begin errors++; $display("FAIL slt_signed: got %h expected 1", em_alu_out); end
    checks++; if (em_wdata !== 32'h55 || em_MemWrite !== 1'b1) begin errors++; $display("FAIL slt_wdata: got %h %b expected 55 1", em_wdata, em_MemWrite); end
    // add wraps modulo 2^32
    clear_inputs();
    in_valid = 1; ALUctr2 = 2'b00; busA2 = 32'hFFFF_FFFF; busB2 = 2; MemtoReg2 = 1;
    step();
    checks++; if (em_alu_out !== 32'd1 || em_MemtoReg !== 1'b1) begin errors++; $display("FAIL add_wrap: got %h %b expected 1 1", em_alu_out, em_MemtoReg); end
    // or with immediate
    clear_inputs();
    in_valid = 1; ALUctr2 = 2'b10; busA2 = 32'hF0; busB2 = 32'h1; ALUSrc2 = 1; Ext_out2 = 32'h0F;
    step();
    checks++; if (em_alu_out !== 32'hFF) begin errors++; $display("FAIL or_imm: got %h expected ff", em_alu_out); end
    // signed 5 < 3 is false
    clear_inputs();
    in_valid = 1; ALUctr2 = 2'b11; busA2 = 5; busB2 = 3;
    step();
    checks++; if (em_alu_out !== 32'd0) begin errors++; $display("FAIL slt_false: got %h expected 0", em_alu_out); end
    // nothing accepted, mem_ready=1 -> entry drains
    clear_inputs();
    step();
    checks++; if (em_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", em_valid); end
  endtask

  task automatic test_branch();
    clear_inputs();
    in_valid = 1; nPC_sel2 = 1; busA2 = 3; busB2 = 3; pc2 = 32'h100; Ext_out2 = 32'hFFFF_FFFF; ALUctr2 = 2'b01;
    step();
    checks++; if (redirect !== 1'b1 || flush !== 1'b1) begin errors++; $display("FAIL br_redirect: got %b/%b expected 1/1", redirect, flush); end
    checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL br_target: got %h expected 00000100", redirect_pc); end
    checks++; if (em_valid !== 1'b1 || em_alu_out !== 32'd0) begin errors++; $display("FAIL br_entry: got %b %h expected 1 0", em_valid, em_alu_out); end
    // SQUASH: following entry is discarded
    clear_inputs();
    in_valid = 1; busA2 = 10; busB2 = 20; RW2 = 5'd9; nPC_sel2 = 1;
    busB2 = 10;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL squash_ready: got %b expected 1", in_ready); end
    step();
    checks++; if (redirect !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL squash_redirect_drop: got %b/%b expected 0/0", redirect, flush); end
    checks++; if (em_valid !== 1'b0) begin errors++; $display("FAIL squash_discard: got %b expected 0", em_valid); end
    // Back in RUN: unequal operands, not taken
    clear_inputs();
    in_valid = 1; nPC_sel2 = 1; busA2 = 3; busB2 = 4; RW2 = 5'd2;
    step();
    checks++; if (redirect !== 1'b0 || em_valid !== 1'b1 || em_RW !== 5'd2) begin errors++; $display("FAIL br_not_taken: got %b %b %0d expected 0 1 2", redirect, em_valid, em_RW); end
  endtask

  task automatic test_jump();
    clear_inputs();
    in_valid = 1; jmp2 = 1; nPC_sel2 = 1; busA2 = 1; busB2 = 1; pc2 = 32'h3000_0000; Ext_out2 = 32'h40;
    step();
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h3000_0100) begin errors++; $display("FAIL jmp_target: got %b %h expected 1 30000100", redirect, redirect_pc); end
    clear_inputs();
    step();
    checks++; if (redirect !== 1'b0 || redirect_pc !== 32'h3000_0100) begin errors++; $display("FAIL jmp_one_cycle: got %b %h expected 0 30000100", redirect, redirect_pc); end
  endtask

  task automatic test_stall();
    clear_inputs();
    in_valid = 1; busA2 = 1; busB2 = 2; RW2 = 5'd4; MemWrite2 = 1;
    step();
    checks++; if (em_valid !== 1'b1 || em_alu_out !== 32'd3) begin errors++; $display("FAIL stall_first: got %b %h expected 1 3", em_valid, em_alu_out); end
    in_valid = 1; busA2 = 100; busB2 = 200; RW2 = 5'd8; MemWrite2 = 0; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b expected 0", in_ready); end
      step();
      checks++; if (em_valid !== 1'b1 || em_alu_out !== 32'd3 || em_wdata !== 32'd2 || em_RW !== 5'd4 || em_MemWrite !== 1'b1) begin errors++; $display("FAIL stall_hold: got %b %h %h %0d %b expected 1 3 2 4 1", em_valid, em_alu_out, em_wdata, em_RW, em_MemWrite); end
    end
    mem_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b expected 1", in_ready); end
    step();
    checks++; if (em_valid !== 1'b1 || em_alu_out !== 32'd300 || em_wdata !== 32'd200 || em_RW !== 5'd8) begin errors++; $display("FAIL stall_new_entry: got %b %h %h %0d expected 1 12c c8 8", em_valid, em_alu_out, em_wdata, em_RW); end
  endtask

  task automatic test_reset_squash();
    clear_inputs();
    in_valid = 1; nPC_sel2 = 1; busA2 = 7; busB2 = 7; pc2 = 32'h200; Ext_out2 = 32'h4;
    step();
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h214) begin errors++; $display("FAIL rs_setup: got %b %h expected 1 00000214", redirect, redirect_pc); end
    #2;
    rst = 0;
    #1;
    checks++; if (redirect !== 1'b0 || flush !== 1'b0 || em_valid !== 1'b0) begin errors++; $display("FAIL rs_async: got %b %b %b expected 0 0 0", redirect, flush, em_valid); end
    checks++; if (redirect_pc !== 32'd0) begin errors++; $display("FAIL rs_pc: got %h expected 0", redirect_pc); end
    step();
    rst = 1;
    clear_inputs();
    in_valid = 1; busA2 = 2; busB2 = 3;
    step();
    checks++; if (em_valid !== 1'b1 || em_alu_out !== 32'd5 || redirect !== 1'b0) begin errors++; $display("FAIL rs_first_accept: got %b %h %b expected 1 5 0", em_valid, em_alu_out, redirect); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_jump();
    test_stall();
    test_reset_squash();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_ex_stage.md
BRANCH_EX_STAGE -- requirements
Module: branch_ex_stage

Interface
REQ-001 SHALL provide: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: in_valid  in  1  ID/EX register holds a valid instruction.
REQ-004 SHALL provide: in_ready  out  1  stage consumes the ID/EX entry this cycle.
REQ-005 SHALL provide: pc2  in  32  PC of the ID/EX instruction.
REQ-006 SHALL provide: ALUSrc2, MemtoReg2, RegWrite2, MemWrite2, nPC_sel2, jmp2  in  1 each  ID/EX control bits.
REQ-007 SHALL provide: ALUctr2  in  2  ALU operation.
REQ-008 SHALL provide: busA2, busB2, Ext_out2  in  32 each  ID/EX operands and extended immediate.
REQ-009 SHALL provide: RW2  in  5  destination register.
REQ-010 SHALL provide: mem_ready  in  1  MEM stage accepts the EX/MEM entry.
REQ-011 SHALL provide: em_valid  out  1  EX/MEM entry valid.
REQ-012 SHALL provide: em_alu_out, em_wdata  out  32 each  ALU result and store data.
REQ-013 SHALL provide: em_RW  out  5; em_MemtoReg, em_RegWrite, em_MemWrite  out  1 each.
REQ-014 SHALL provide: redirect  out  1  one-cycle PC redirect pulse.
REQ-015 SHALL provide: redirect_pc  out  32  target PC, valid while redirect=1.
REQ-016 SHALL provide: flush  out  1  one-cycle clear of IF/ID, coincident with redirect.

Function
REQ-017 SHALL set B = Ext_out2 when ALUSrc2=1, else busB2.
REQ-018 SHALL compute the ALU result by ALUctr2:
- 00: A+B
- 01: A-B
- 10: A|B
- 11: signed A<B -> 1, else 0
- A+B and A-B wrap modulo 2^32; no overflow flag.
REQ-019 SHALL take a branch when nPC_sel2=1 and busA2==busB2, always using busB2; target = pc2+4+(Ext_out2<<2), modulo 2^32.
REQ-020 SHALL take a jump when jmp2=1; target = {(pc2+4)[31:28], Ext_out2[25:0], 2'b00}; jmp2 takes priority over nPC_sel2.
REQ-021 SHALL assert in_ready = (state==SQUASH) | !em_valid | mem_ready.
REQ-022 SHALL treat an entry as accepted when in_valid & in_ready.
REQ-023 SHALL, on acceptance in RUN, load the EX/MEM registers:
- em_valid=1
- ALU result into em_alu_out
- busB2 into em_wdata
- RW2 and the three control bits into em_RW, em_MemtoReg, em_RegWrite, em_MemWrite
- latency exactly one cycle.
REQ-024 SHALL clear em_valid at the edge when em_valid=1, mem_ready=1 and no entry is accepted.
REQ-025 SHALL hold all em_* outputs unchanged while em_valid=1 and mem_ready=0.
REQ-026 SHALL have two states, RUN and SQUASH.
REQ-027 SHALL, on accepting a taken branch or jump in RUN, at the next edge:
- set redirect=1, flush=1, redirect_pc=target
- enter SQUASH.
REQ-028 SHALL, in SQUASH:
- discard any presented entry (in_ready=1, no em load, no redirect evaluation)
- deassert redirect and flush at the next edge
- return to RUN after exactly one cycle, regardless of in_valid and mem_ready.
REQ-029 SHALL still pass taken branches and jumps to EX/MEM as normal entries (carrying their own control bits).
REQ-030 SHALL never assert redirect for two consecutive cycles.
REQ-031 SHALL drive redirect and flush from registers (no combinational path from inputs).

Reset
REQ-032 SHALL, while rst=0 (asynchronous), force:
- state=RUN
- em_valid, em_MemtoReg, em_RegWrite, em_MemWrite=0
- em_alu_out, em_wdata, em_RW=0
- redirect, flush=0, redirect_pc=0.
REQ-033 SHALL, on reset asserted mid-SQUASH or mid-stall, drop any pending redirect and entry; the first acceptance is possible on the first rising edge after rst returns to 1.

Verification
REQ-034 SHALL cover: ALUctr2=01, busA2=5, busB2=7, ALUSrc2=0, mem_ready=1 -> next cycle em_valid=1, em_alu_out=0xFFFFFFFE.
REQ-035 SHALL cover: ALUctr2=11, busA2=0xFFFFFFFF, ALUSrc2=1, Ext_out2=1 -> em_alu_out=1.
REQ-036 SHALL cover: nPC_sel2=1, busA2=busB2=3, pc2=0x100, Ext_out2=0xFFFFFFFF -> next cycle redirect=1, flush=1, redirect_pc=0x100; following entry discarded; redirect=0 after one cycle.
REQ-037 SHALL cover: jmp2=1, nPC_sel2=1, pc2=0x3000_0000, Ext_out2=0x40 -> redirect_pc=0x3000_0100.
REQ-038 SHALL cover: em_valid=1, mem_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and em_* stable; mem_ready=1 -> new entry loaded the next edge.
REQ-039 SHALL cover: rst=0 asserted during SQUASH -> redirect, flush, em_valid=0 immediately, no clock edge required.
